// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized input, mid-bit sampling from a baud counter,
// one-cycle valid / frame_err pulses per completed frame.
module uart_rx #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int HALF_DIV = BAUD_DIV / 2;
    localparam int CW       = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_END = CW'(HALF_DIV - 1);
    localparam logic [CW-1:0] BAUD_END = CW'(BAUD_DIV - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic          sync1, rx_s, rx_d;
    logic [1:0]    settle;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          stop_ok, stop_bad;
    logic          start_edge;

    // Edges are only trusted once rx_d holds a real line sample; otherwise a line
    // that is low when reset releases would look like a 1-to-0 edge.
    assign start_edge = (settle == 2'd3) && rx_d && !rx_s;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b1;
            rx_s   <= 1'b1;
            rx_d   <= 1'b1;
            settle <= 2'd0;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
            rx_d  <= rx_s;
            if (settle != 2'd3) settle <= settle + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            stop_ok   <= 1'b0;
            stop_bad  <= 1'b0;
            data_out  <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // Stop-bit verdict is published one edge after the sample.
            stop_ok   <= 1'b0;
            stop_bad  <= 1'b0;
            valid     <= stop_ok;
            frame_err <= stop_bad;
            if (stop_ok) data_out <= shift;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start_edge) state <= START;
                end
                START: begin
                    if (cnt == HALF_END) begin
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BAUD_END) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BAUD_END) begin
                        cnt      <= '0;
                        state    <= IDLE;
                        stop_ok  <= rx_s;
                        stop_bad <= !rx_s;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
